alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Registered output stage that sits directly downstream of the ALU's 4:1 operation-select multiplexers.
- Captures the selected 24-bit result together with its carry and overflow bits.
- Generates zero and negative flags and presents result plus flags to write-back through a valid/ready handshake.
- A two-entry skid buffer decouples ALU timing from write-back stalls without dropping a result.

Parameters:
- WIDTH, 24, data width of the ALU result in bits.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset.
- Clear  input  1  synchronous flush of buffered results (pipeline squash).
- HyrjaRez  input  WIDTH  result word from the ALU select multiplexers.
- HyrjaC  input  1  carry-out belonging to HyrjaRez.
- HyrjaV  input  1  overflow belonging to HyrjaRez.
- HyrjaValid  input  1  upstream result valid.
- HyrjaReady  output  1  stage can accept a result this cycle.
- DaljaRez  output  WIDTH  registered result.
- DaljaZ  output  1  zero flag.
- DaljaN  output  1  negative flag.
- DaljaC  output  1  carry flag.
- DaljaV  output  1  overflow flag.
- DaljaP  output  1  parity flag (only with the optional feature; otherwise tied 0).
- DaljaValid  output  1  result/flags valid.
- DaljaReady  input  1  downstream accepts the result.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low. When Reset=0 at a rising edge:
  - DaljaValid=0, DaljaRez=0, all flags=0.
  - Skid entry empty.
  - HyrjaReady=0 while Reset is low and 1 in the first cycle after release.
- Storage: two entries, main (drives the outputs) and skid. Each entry holds {rez, Z, N, C, V[, P]}.
- Flag computation, done at capture time from the input word:
  - Z = (HyrjaRez == 0).
  - N = HyrjaRez[WIDTH-1].
  - C = HyrjaC, V = HyrjaV.
  - Flags travel with their word and are never recomputed.
- Handshake:
  - Accept = HyrjaValid & HyrjaReady.
  - Emit = DaljaValid & DaljaReady.
  - HyrjaReady is registered and equals !skid_valid.
  - DaljaValid = main_valid.
  - DaljaRez and flags hold stable while DaljaValid=1 and DaljaReady=0.
- Latency: 1 cycle from accept to DaljaValid when main is empty or being emitted. Throughput is 1 result/cycle when DaljaReady=1.
- Transitions (main_valid, skid_valid):
  - (0,0) + accept -> (1,0), main = input.
  - (1,0) + accept + emit -> (1,0), main = input.
  - (1,0) + accept, no emit -> (1,1), skid = input, HyrjaReady drops next cycle.
  - (1,0) + emit, no accept -> (0,0).
  - (1,1) + emit -> (1,0), main = skid. No accept is possible because HyrjaReady=0.
  - (1,1), no emit -> hold.
- Boundaries:
  - Full = skid_valid. HyrjaValid while full is ignored; upstream must hold its data.
  - Data is never lost or duplicated.
  - Clear=1 at an edge -> both entries invalid and DaljaValid=0 next cycle. Data registers need not be zeroed.
  - Clear overrides a simultaneous accept (the accepted word is discarded) and a simultaneous emit (the emit still counts as consumed downstream).
  - Reset asserted mid-transfer behaves the same as Clear, plus the output registers are zeroed. Reset has priority over Clear.
  - DaljaReady=1 while DaljaValid=0 has no effect.

Optional Feature:
- Macro: ALU_PARITY_FLAG_EN.
- Defined:
  - Each entry stores P = ~^HyrjaRez (even parity: 1 when the count of ones is even), captured with the other flags.
  - DaljaP drives P; reset/clear behaviour matches the other flags.
- Undefined:
  - No P storage.
  - DaljaP is constant 0.
  - All other behaviour is identical.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with HyrjaValid=1 -> DaljaValid=0, DaljaRez=0, flags=0, HyrjaReady=0. After release, HyrjaReady=1.
- Flag generation:
  - Accept 0x000000, C=1, V=0 with DaljaReady=1 -> next cycle DaljaRez=0x000000, Z=1, N=0, C=1, V=0.
  - Then 0x800001 -> Z=0, N=1.
- Stall/skid:
  - DaljaReady=0; accept 0x000011 then 0x000022 -> HyrjaReady=0 and DaljaRez holds 0x000011.
  - Raise DaljaReady -> outputs 0x000011 then 0x000022 in consecutive cycles; HyrjaReady returns to 1.
- Streaming: 8 back-to-back words 0x000001..0x000008 with DaljaReady=1 -> 8 consecutive DaljaValid cycles, in order, 1-cycle latency.
- Clear: skid full (0x0000AA, 0x0000BB), assert Clear together with HyrjaValid carrying 0x0000CC -> DaljaValid=0 next cycle and 0x0000CC never appears.
- Parity (with ALU_PARITY_FLAG_EN): 0x000003 -> DaljaP=1; 0x000007 -> DaljaP=0. Without the macro, DaljaP=0 for both.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result stage: registers the selected result, derives Z/N flags and hands off via valid/ready.
// Latency 1 cycle from accept to DaljaValid; sustains 1 result/cycle while DaljaReady is high.
// Two-entry skid buffer; HyrjaReady is registered and drops only while the skid entry is occupied.
// Optional parity flag DaljaP is enabled by defining ALU_PARITY_FLAG_EN.
module alu_result_stage #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic [WIDTH-1:0] HyrjaRez,
    input  logic             HyrjaC,
    input  logic             HyrjaV,
    input  logic             HyrjaValid,
    output logic             HyrjaReady,
    output logic [WIDTH-1:0] DaljaRez,
    output logic             DaljaZ,
    output logic             DaljaN,
    output logic             DaljaC,
    output logic             DaljaV,
    output logic             DaljaP,
    output logic             DaljaValid,
    input  logic             DaljaReady
);

    typedef struct packed {
        logic [WIDTH-1:0] rez;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
`ifdef ALU_PARITY_FLAG_EN
        logic             p;
`endif
    } entry_t;

    entry_t in_ent;
    entry_t main_q;
    entry_t main_nxt;
    entry_t skid_q;
    entry_t skid_nxt;
    logic   main_valid_q;
    logic   main_valid_nxt;
    logic   skid_valid_q;
    logic   skid_valid_nxt;
    logic   ready_q;
    logic   accept;
    logic   emit;

    assign accept = HyrjaValid & ready_q;
    assign emit   = main_valid_q & DaljaReady;

    // Flags are fixed at capture and travel with the word from here on.
    always_comb begin
        in_ent     = '0;
        in_ent.rez = HyrjaRez;
        in_ent.z   = (HyrjaRez == '0);
        in_ent.n   = HyrjaRez[WIDTH-1];
        in_ent.c   = HyrjaC;
        in_ent.v   = HyrjaV;
`ifdef ALU_PARITY_FLAG_EN
        in_ent.p   = ~^HyrjaRez;
`endif
    end

    always_comb begin
        main_nxt       = main_q;
        skid_nxt       = skid_q;
        main_valid_nxt = main_valid_q;
        skid_valid_nxt = skid_valid_q;
        if (Clear) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept) begin
                        main_nxt       = in_ent;
                        main_valid_nxt = 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && emit) begin
                        main_nxt = in_ent;
                    end else if (accept) begin
                        skid_nxt       = in_ent;
                        skid_valid_nxt = 1'b1;
                    end else if (emit) begin
                        main_valid_nxt = 1'b0;
                    end
                end
                2'b11: begin
                    // Upstream is stalled here, so only the skid entry can refill main.
                    if (emit) begin
                        main_nxt       = skid_q;
                        skid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    main_valid_nxt = 1'b0;
                    skid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_q       <= main_nxt;
            skid_q       <= skid_nxt;
            main_valid_q <= main_valid_nxt;
            skid_valid_q <= skid_valid_nxt;
            ready_q      <= ~skid_valid_nxt;
        end
    end

    assign HyrjaReady = ready_q;
    assign DaljaValid = main_valid_q;
    assign DaljaRez   = main_q.rez;
    assign DaljaZ     = main_q.z;
    assign DaljaN     = main_q.n;
    assign DaljaC     = main_q.c;
    assign DaljaV     = main_q.v;
`ifdef ALU_PARITY_FLAG_EN
    assign DaljaP     = main_q.p;
`else
    assign DaljaP     = 1'b0;
`endif

endmodule
